// File: rtl/data_mem_responder.sv
// data_mem_responder: target side of the core's data-memory port.
// Accepts one load/store at a time, inserts WAIT_STATES wait cycles, then
// completes with a single-cycle data_mem_ack. Behind the port sit a word RAM
// and a small MMIO block (free-running timer plus a 3-source interrupt
// controller that drives the core's interrupts input).
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        data_mem_ack,
    input  logic [1:0]  ext_irq,
    output logic [2:0]  interrupts
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    // Counter preload: the WAIT state lasts WAIT_STATES cycles, ending when it reads 0.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [3:0] REG_TIMER_COUNT = 4'h0;
    localparam logic [3:0] REG_TIMER_CMP   = 4'h1;
    localparam logic [3:0] REG_IRQ_PENDING = 4'h2;
    localparam logic [3:0] REG_IRQ_ENABLE  = 4'h3;

    // Transaction control
    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic        r_write;
    logic        r_ack;
    logic [31:0] r_rdata;

    // Latched request payload (data path, no reset)
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    // MMIO state
    logic [31:0] r_timer;
    logic [31:0] r_cmp;
    logic [2:0]  r_pend;
    logic [2:0]  r_en;
    logic [1:0]  r_ext_prev;
    logic [2:0]  r_irq;

    // Word RAM (contents survive reset)
    logic [31:0] r_mem [DEPTH_WORDS];

    // Decode of the latched request
    logic              w_is_mmio;
    logic [3:0]        w_reg_idx;
    logic [ADDR_W-1:0] w_ram_idx;
    logic              w_commit;
    logic              w_mmio_wr;
    logic              w_ram_wr;

    // Load path: address/direction seen on the cycle that enters ACK
    logic              w_capture;
    logic              w_enter_ack;
    logic [31:0]       w_rd_addr;
    logic              w_rd_write;

    // MMIO next-state values
    logic [31:0] w_timer_next;
    logic [31:0] w_cmp_next;
    logic        w_match;
    logic [1:0]  w_rise;
    logic [2:0]  w_pend_set;
    logic [2:0]  w_pend_clr;
    logic [2:0]  w_pend_next;
    logic [2:0]  w_en_next;

    // Byte-offset and unmapped address bits carry no meaning here.
    logic w_unused_addr_bits;

    assign w_is_mmio = (r_addr[31:16] == 16'hFFFF);
    assign w_reg_idx = r_addr[5:2];
    assign w_ram_idx = r_addr[ADDR_W+1:2];

    // Stores take effect on the edge that leaves ACK.
    assign w_commit  = (r_state == S_ACK) && r_write;
    assign w_mmio_wr = w_commit && w_is_mmio;
    assign w_ram_wr  = w_commit && !w_is_mmio;

    assign w_capture   = (r_state == S_IDLE) && mem_req;
    assign w_enter_ack = ((r_state == S_WAIT) && (r_wait_cnt == 4'd0)) ||
                         (w_capture && (WAIT_STATES == 0));

    // With zero wait states ACK is entered straight from IDLE, before the
    // request has been latched, so the live port values are used instead.
    assign w_rd_addr  = (r_state == S_IDLE) ? addr      : r_addr;
    assign w_rd_write = (r_state == S_IDLE) ? mem_write : r_write;

    // A CPU write to the count wins over that cycle's increment.
    assign w_timer_next = (w_mmio_wr && (w_reg_idx == REG_TIMER_COUNT)) ? r_wdata
                                                                        : r_timer + 32'd1;
    assign w_cmp_next   = (w_mmio_wr && (w_reg_idx == REG_TIMER_CMP)) ? r_wdata : r_cmp;

    // Compare uses the pre-increment count.
    assign w_match    = (r_timer == r_cmp);
    assign w_rise     = ext_irq & ~r_ext_prev;
    assign w_pend_set = {w_rise, w_match};
    assign w_pend_clr = (w_mmio_wr && (w_reg_idx == REG_IRQ_PENDING)) ? r_wdata[2:0] : 3'b000;
    // Set wins over a simultaneous write-1-to-clear.
    assign w_pend_next = (r_pend & ~w_pend_clr) | w_pend_set;
    assign w_en_next   = (w_mmio_wr && (w_reg_idx == REG_IRQ_ENABLE)) ? r_wdata[2:0] : r_en;

    assign w_unused_addr_bits = ^{w_rd_addr[1:0], w_rd_addr[15:6], r_addr[1:0], r_addr[15:6]};

    assign read_data    = r_rdata;
    assign data_mem_ack = r_ack;
    assign interrupts   = r_irq;

    // Read mux over RAM and MMIO registers; unmapped offsets and bits read 0.
    function automatic logic [31:0] f_read(input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a[31:16] == 16'hFFFF) begin
            case (a[5:2])
                REG_TIMER_COUNT: v = r_timer;
                REG_TIMER_CMP:   v = r_cmp;
                REG_IRQ_PENDING: v = {29'd0, r_pend};
                REG_IRQ_ENABLE:  v = {29'd0, r_en};
                default:         v = 32'd0;
            endcase
        end else begin
            v = r_mem[a[ADDR_W+1:2]];
        end
        return v;
    endfunction

    // Request FSM: IDLE -> (WAIT) -> ACK, with registered ack and load data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_write    <= 1'b0;
            r_ack      <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_req) begin
                        r_write <= mem_write;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state    <= S_WAIT;
                            r_wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_enter_ack && !w_rd_write) begin
                r_rdata <= f_read(w_rd_addr);
            end
        end
    end

    // Latch the request payload when it is accepted.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_addr  <= addr;
            r_wdata <= write_data;
        end
    end

    // Word RAM write port, committed on the edge leaving ACK.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_mem[w_ram_idx] <= r_wdata;
        end
    end

    // Timer, interrupt controller and registered interrupt outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer    <= 32'd0;
            r_cmp      <= 32'hFFFF_FFFF;
            r_pend     <= 3'b000;
            r_en       <= 3'b000;
            r_ext_prev <= 2'b00;
            r_irq      <= 3'b000;
        end else begin
            r_timer    <= w_timer_next;
            r_cmp      <= w_cmp_next;
            r_pend     <= w_pend_next;
            r_en       <= w_en_next;
            r_ext_prev <= ext_irq;
            r_irq      <= w_pend_next & w_en_next;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with 2 wait states, one with 0.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wd, m_rd;
    logic [1:0]  m_ext;
    logic [2:0]  m_int;
    logic        z_req, z_we, z_ack;
    logic [31:0] z_addr, z_wd, z_rd;
    logic [1:0]  z_ext;
    logic [2:0]  z_int;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    bit raise_ext0 = 1'b0;
    int commit_cyc = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .reset(rst), .mem_req(m_req), .mem_write(m_we), .addr(m_addr),
        .write_data(m_wd), .read_data(m_rd), .data_mem_ack(m_ack), .ext_irq(m_ext),
        .interrupts(m_int)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(rst), .mem_req(z_req), .mem_write(z_we), .addr(z_addr),
        .write_data(z_wd), .read_data(z_rd), .data_mem_ack(z_ack), .ext_irq(z_ext),
        .interrupts(z_int)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // One complete transaction. Returns load data and the number of edges from
    // capture (counted as 1) to the edge after which ack is seen high. Ends
    // #1 after the commit edge, with the DUT back in IDLE.
    task automatic access(input bit sel, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        logic ack;
        if (sel) begin z_req = 1'b1; z_we = we; z_addr = a; z_wd = wd; end
        else     begin m_req = 1'b1; m_we = we; m_addr = a; m_wd = wd; end
        @(posedge clk); #1;
        lat = 1;
        ack = sel ? z_ack : m_ack;
        while (!ack && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            ack = sel ? z_ack : m_ack;
        end
        if (!ack) chk("ack_timeout", 32'd0, 32'd1);
        rd = sel ? z_rd : m_rd;
        if (sel) z_req = 1'b0; else m_req = 1'b0;
        if (raise_ext0) m_ext[0] = 1'b1;
        @(posedge clk); #1;
        commit_cyc = cyc;
        ack = sel ? z_ack : m_ack;
        chk("ack_one_cycle", {31'd0, ack}, 32'd0);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;   // read_data after the ack (stores leave it unchanged)
    } vec_t;

    initial begin
        vec_t        vt [14];
        logic [31:0] rd, v, a, last_m, last_z;
        logic [31:0] mm [64];
        logic [31:0] zm [16];
        logic [2:0]  en_m;
        logic [5:0]  idx;
        logic [3:0]  zidx;
        int          lat, kind, e_cnt, rise;
        bit          we, dropped;

        vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 32'h0000_1010, 32'hCAFE_F00D, 32'hDEAD_BEEF};
        vt[3]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hCAFE_F00D};
        vt[4]  = '{1'b0, 32'hFFFF_0004, 32'h0,         32'hFFFF_FFFF};
        vt[5]  = '{1'b1, 32'hFFFF_000C, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vt[6]  = '{1'b0, 32'hFFFF_000C, 32'h0,         32'h0000_0007};
        vt[7]  = '{1'b1, 32'hFFFF_0010, 32'h1234_5678, 32'h0000_0007};
        vt[8]  = '{1'b0, 32'hFFFF_0010, 32'h0,         32'h0000_0000};
        vt[9]  = '{1'b0, 32'hFFFF_003C, 32'h0,         32'h0000_0000};
        vt[10] = '{1'b1, 32'hFFFF_000C, 32'h0,         32'h0000_0000};
        vt[11] = '{1'b0, 32'hFFFF_000C, 32'h0,         32'h0000_0000};
        vt[12] = '{1'b0, 32'hFFFF_0008, 32'h0,         32'h0000_0000};
        vt[13] = '{1'b0, 32'h0001_0010, 32'h0,         32'hCAFE_F00D};

        rst = 1'b1;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_ext = 2'b00;
        z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wd = '0; z_ext = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, m_ack}, 32'd0);
        chk("rst_rdata", m_rd, 32'd0);
        chk("rst_int", {29'd0, m_int}, 32'd0);
        chk("rst_ack_ws0", {31'd0, z_ack}, 32'd0);
        chk("rst_rdata_ws0", z_rd, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table at 2 wait states
        for (int i = 0; i < 14; i++) begin
            access(0, vt[i].we, vt[i].a, vt[i].wd, rd, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
        end
        last_m = vt[13].exp;
        en_m   = 3'b000;

        // Zero wait states with address aliasing
        access(1, 1'b1, 32'h0000_1010, 32'h0000_1234, rd, lat);
        chk("ws0_store_lat", 32'(lat), 32'd1);
        access(1, 1'b0, 32'h0000_0010, 32'h0, rd, lat);
        chk("ws0_alias_rdata", rd, 32'h0000_1234);
        chk("ws0_load_lat", 32'(lat), 32'd1);
        last_z = 32'h0000_1234;

        // Randomized traffic against an array model
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            mm[i] = v;
            access(0, 1'b1, 32'(i) << 2, v, rd, lat);
        end
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 7);
            we   = 1'($urandom_range(0, 1));
            v    = $urandom;
            if (kind == 0) begin
                access(0, we, 32'hFFFF_000C, v, rd, lat);
                if (we) en_m = v[2:0];
                else    last_m = {29'd0, en_m};
            end else begin
                idx = 6'($urandom_range(0, 63));
                a   = {1'b0, 19'($urandom), 4'd0, idx, 2'($urandom)};
                access(0, we, a, v, rd, lat);
                if (we) mm[idx] = v;
                else    last_m = mm[idx];
            end
            chk("rand_rdata", rd, last_m);
            chk("rand_lat", 32'(lat), 32'd3);
        end
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            zm[i] = v;
            access(1, 1'b1, 32'(i) << 2, v, rd, lat);
        end
        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom_range(0, 1));
            v    = $urandom;
            zidx = 4'($urandom_range(0, 15));
            a    = {1'b0, 19'($urandom), 4'd0, 2'd0, zidx, 2'($urandom)};
            access(1, we, a, v, rd, lat);
            if (we) zm[zidx] = v;
            else    last_z = zm[zidx];
            chk("rand_ws0_rdata", rd, last_z);
            chk("rand_ws0_lat", 32'(lat), 32'd1);
        end

        // Timer compare interrupt
        access(0, 1'b1, 32'hFFFF_000C, 32'd1, rd, lat);
        access(0, 1'b1, 32'hFFFF_0000, 32'd0, rd, lat);
        e_cnt = commit_cyc;
        access(0, 1'b1, 32'hFFFF_0004, 32'd20, rd, lat);
        chk("timer_int_before", {31'd0, m_int[0]}, 32'd0);
        rise = -1;
        for (int k = 0; k < 60; k++) begin
            if (m_int[0]) begin
                rise = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        // Count is 0 after the load edge; the edge that sees 20 is 21 edges later.
        chk("timer_irq_cycle", 32'(rise), 32'(e_cnt + 21));
        dropped = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (!m_int[0]) dropped = 1'b1;
        end
        chk("timer_irq_held", {31'd0, dropped}, 32'd0);
        access(0, 1'b0, 32'hFFFF_0008, 32'd0, rd, lat);
        chk("timer_pending", rd, 32'd1);
        access(0, 1'b1, 32'hFFFF_0008, 32'd1, rd, lat);
        chk("timer_w1c_int", {31'd0, m_int[0]}, 32'd0);
        access(0, 1'b0, 32'hFFFF_0008, 32'd0, rd, lat);
        chk("timer_pending_clr", rd, 32'd0);

        // External edge on ext_irq[1]
        access(0, 1'b1, 32'hFFFF_000C, 32'd4, rd, lat);
        m_ext[1] = 1'b1;
        @(posedge clk); #1;
        chk("ext_rise_int", {29'd0, m_int}, 32'd4);
        access(0, 1'b0, 32'hFFFF_0008, 32'd0, rd, lat);
        chk("ext_pending", rd, 32'd4);
        access(0, 1'b1, 32'hFFFF_0008, 32'd4, rd, lat);
        chk("ext_w1c_level_high", {29'd0, m_int}, 32'd0);
        @(posedge clk); #1;
        chk("ext_no_reset_level", {29'd0, m_int}, 32'd0);
        m_ext[1] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("ext_fall_no_set", {29'd0, m_int}, 32'd0);
        m_ext[1] = 1'b1;
        @(posedge clk); #1;
        chk("ext_second_edge", {29'd0, m_int}, 32'd4);
        access(0, 1'b1, 32'hFFFF_0008, 32'd4, rd, lat);
        m_ext[1] = 1'b0;

        // Set and clear of pending[1] on the same edge
        access(0, 1'b1, 32'hFFFF_000C, 32'd2, rd, lat);
        m_ext[0] = 1'b1;
        @(posedge clk); #1;
        m_ext[0] = 1'b0;
        @(posedge clk); #1;
        chk("sc_pre_int", {29'd0, m_int}, 32'd2);
        raise_ext0 = 1'b1;
        access(0, 1'b1, 32'hFFFF_0008, 32'd2, rd, lat);
        raise_ext0 = 1'b0;
        chk("set_beats_clear", {29'd0, m_int}, 32'd2);
        access(0, 1'b0, 32'hFFFF_0008, 32'd0, rd, lat);
        chk("sc_pending", rd, 32'd2);
        access(0, 1'b1, 32'hFFFF_0008, 32'd2, rd, lat);
        chk("sc_plain_clear", {29'd0, m_int}, 32'd0);
        m_ext[0] = 1'b0;
        @(posedge clk); #1;
        m_ext[0] = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_int", {29'd0, m_int}, 32'd2);

        // Reset in the middle of a store
        access(0, 1'b1, 32'h0000_0040, 32'hAAAA_5555, rd, lat);
        access(0, 1'b0, 32'h0000_0040, 32'd0, rd, lat);
        chk("pre_reset_load", rd, 32'hAAAA_5555);
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0040; m_wd = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_ack", {31'd0, m_ack}, 32'd0);
        chk("midrst_rdata", m_rd, 32'd0);
        chk("midrst_int", {29'd0, m_int}, 32'd0);
        m_req = 1'b0; m_we = 1'b0;
        m_ext = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_ack_held", {31'd0, m_ack}, 32'd0);
        rst = 1'b0;
        // Count restarts at 0: edges at capture and the one wait cycle precede the read.
        access(0, 1'b0, 32'hFFFF_0000, 32'd0, rd, lat);
        chk("post_rst_timer", rd, 32'd2);
        chk("post_rst_lat", 32'(lat), 32'd3);
        access(0, 1'b0, 32'h0000_0040, 32'd0, rd, lat);
        chk("store_discarded", rd, 32'hAAAA_5555);
        access(0, 1'b0, 32'hFFFF_0004, 32'd0, rd, lat);
        chk("post_rst_cmp", rd, 32'hFFFF_FFFF);
        access(0, 1'b0, 32'hFFFF_000C, 32'd0, rd, lat);
        chk("post_rst_en", rd, 32'd0);
        access(0, 1'b0, 32'hFFFF_0008, 32'd0, rd, lat);
        chk("post_rst_pend", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Target-side end of the core's data-memory port. Accepts load/store requests, inserts a configurable number of wait states, and completes each request with a one-cycle acknowledge (data_mem_ack).
- Contains the word RAM and a small MMIO block: a timer plus an interrupt controller. The interrupt controller drives the core's 3-bit interrupts input.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words (power of 2).
- ADDR_W, 10: log2(DEPTH_WORDS).
- WAIT_STATES, 2: extra cycles between request capture and ack (0..15).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- mem_req  input  1  access request; held high by the core until ack
- mem_write  input  1  1 = store, 0 = load (qualified by mem_req)
- addr  input  32  byte address; addr[1:0] ignored
- write_data  input  32  store data
- read_data  output  32  load data, valid in ack cycle
- data_mem_ack  output  1  one-cycle completion pulse
- ext_irq  input  2  external interrupt levels (e.g. VGA vsync)
- interrupts  output  3  enabled pending interrupts to core

Behaviour:
- One clock: clk. Reset is asynchronous and active-high.
- Reset values:
  - state IDLE, data_mem_ack 0, read_data 0, interrupts 0.
  - TIMER_COUNT 0, TIMER_CMP 32'hFFFFFFFF, IRQ_PENDING 0, IRQ_ENABLE 0, ext_irq history 0.
  - RAM contents are not reset.
- FSM:
  - IDLE: on mem_req=1, latch addr, mem_write, write_data. Go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else to ACK.
  - WAIT: decrement counter; when it reaches 0, go to ACK.
  - ACK: data_mem_ack=1 for exactly one cycle; go to IDLE unconditionally.
- mem_req is never sampled in WAIT or ACK. A request still high during ACK belongs to the finished transaction. Back-to-back requests therefore have one IDLE cycle between acks.
- Latency: ack is asserted WAIT_STATES+1 cycles after the capture edge.
- Stores: the RAM/MMIO write commits on the edge leaving ACK. read_data is unchanged by stores.
- Loads: read_data is registered on the edge entering ACK and holds its value until the next load's ACK.
- Decode:
  - MMIO when latched addr[31:16]==16'hFFFF. Register index is addr[5:2].
  - Otherwise RAM, word index addr[ADDR_W+1:2]. Upper bits are ignored, so addresses alias modulo DEPTH_WORDS.
- MMIO registers (offset):
  - 0x00 TIMER_COUNT (RW): increments by 1 every cycle and wraps at 2^32. A CPU write loads the written value; the write wins over the increment that cycle.
  - 0x04 TIMER_CMP (RW): compared each cycle against the pre-increment count. On a match, pending[0] is set.
  - 0x08 IRQ_PENDING (R, write-1-to-clear, bits [2:0]):
    - bit0: timer match.
    - bits 1 and 2: rising edges of ext_irq[0] and ext_irq[1], detected against the previous-cycle register.
    - Set and clear in the same cycle: set wins.
  - 0x0C IRQ_ENABLE (RW, bits [2:0]).
  - Other offsets read 0; writes to them are ignored. Unused register bits read 0.
- interrupts is registered: interrupts <= IRQ_PENDING & IRQ_ENABLE (next-state values). It stays asserted until software clears the pending bit.
- Reset mid-transaction: the FSM returns to IDLE and ack drops immediately (async). An uncommitted store is discarded.
- Partial-word stores are not supported: every store writes the full word.

Test Plan:
- Load/store at WAIT_STATES=2: store 32'hDEADBEEF to 0x0000_0010, then load 0x0000_0010 → each ack exactly 3 cycles after capture, ack high 1 cycle, read_data=32'hDEADBEEF.
- Aliasing and latency 0: at WAIT_STATES=0, store 32'h1234 to 0x0000_1010, then load 0x0000_0010 → read_data=32'h1234, ack 1 cycle after capture.
- Timer interrupt:
  - Write IRQ_ENABLE=3'b001, TIMER_COUNT=0, TIMER_CMP=20 → interrupts[0] rises when count passes 20 and stays high.
  - W1C write of 1 to IRQ_PENDING → interrupts[0] falls the following cycle.
- External edge: hold ext_irq[1] high for 10 cycles with enable=3'b100 → pending[2] is set once. A W1C issued while ext_irq stays high is not re-set; a new 0→1 edge sets it again.
- Set-vs-clear: W1C of bit1 on the same cycle as an ext_irq[0] rising edge → pending[1] remains 1.
- Reset mid-store: assert reset during WAIT → ack=0 and state IDLE immediately; a later load of the target address returns the old data. MMIO registers read their reset values.
